tdec_param_fifo: RTL and testbench
==================================

// Module: tdec_param_fifo
// PURPOSE
//  Parametrised single-clock sync FIFO; next generation of the TDEC wrap buffer.
//  Adds configurable width/depth, true full, occupancy count, almost-empty flag,
//  optional registered read port and sticky overflow/underflow errors.
//  Sits between TDEC wrapper producers and the decoder core.
// PARAMETERS
//  DW        8    data width, bits
//  DEPTH     16   entries; any value >= 2, not restricted to a power of two
//  AW        $clog2(DEPTH)  pointer width; derived, do not override
//  AF_THRES  12   almost_full when count >= AF_THRES (1..DEPTH)
//  AE_THRES  2    almost_empty when count <= AE_THRES (0..DEPTH-1)
//  RD_REG    0    0: show-ahead combinational rd_data; 1: registered rd_data, 1-cycle latency
// PORTS
//  clk               in   1     clock, posedge only
//  rst               in   1     synchronous reset, active-high
//  flush             in   1     sync clear of pointers/count/errors
//  wr_en             in   1     write request
//  wr_data           in   DW    write data
//  rd_en             in   1     read request (pop)
//  rd_data           out  DW    read data
//  rd_valid          out  1     RD_REG=1: rd_data valid pulse; RD_REG=0: = !fifo_empty
//  fifo_empty        out  1     count == 0
//  fifo_full         out  1     count == DEPTH
//  fifo_almost_full  out  1     count >= AF_THRES
//  fifo_almost_empty out  1     count <= AE_THRES
//  fifo_count        out  AW+1  occupancy, 0..DEPTH
//  ovf_err           out  1     sticky: write attempted while full and not popped
//  udf_err           out  1     sticky: read attempted while empty
// BEHAVIOUR
//  - Reset (rst=1 at posedge): ptrs=0, count=0, fifo_empty=1, fifo_almost_empty=1,
//    fifo_full=0, fifo_almost_full=0, rd_valid=0, rd_data reg=0, ovf_err=udf_err=0.
//    Memory not reset. Reset mid-operation discards all contents.
//  - Priority per cycle: rst > flush > rd/wr. flush: same as reset except memory and
//    rd_data reg untouched; concurrent wr_en/rd_en ignored, no error set.
//  - rd_acc = rd_en & !fifo_empty. wr_acc = wr_en & (!fifo_full | rd_acc).
//    Full + wr_en + rd_en: both accepted, count unchanged. Empty + both: write only,
//    udf_err set (no fall-through).
//  - count_nxt = count + wr_acc - rd_acc. All flags are registers computed from
//    count_nxt, so they are valid the cycle after the causing edge; no comb paths to flags.
//  - Pointers wrap DEPTH-1 -> 0 explicitly (compare, not modulo-2^AW).
//  - RD_REG=0: rd_data = mem[rd_ptr], combinational; don't-care while empty.
//  - RD_REG=1: on rd_acc, rd_data <= mem[rd_ptr] and rd_valid <= 1 next cycle;
//    otherwise rd_valid <= 0 and rd_data holds.
//  - ovf_err set when wr_en & fifo_full & !rd_acc; udf_err set when rd_en & fifo_empty.
//    Both cleared only by rst or flush. Rejected write leaves memory/ptrs unchanged.
//  - Illegal parameters (DEPTH<2, thresholds out of range) stop elaboration.
// STRUCTURE
//  - Shared tdec defines include: default DW/DEPTH/threshold constants for TDEC FIFOs.
//  - Sub-module tdec_fifo_ram: DEPTH x DW, 1 write / 1 async-read port, no reset.
//  - Top holds pointers, counter, flag registers, error sticky bits, RD_REG generate.
// TESTING (DEPTH=16, DW=8, AF=12, AE=2 unless noted)
//  1. Reset then write 0x00..0x0F, 16 cycles -> count 16, full=1, almost_full from
//     count 12, almost_empty=0 from count 3; 17th write sets ovf_err, data intact.
//  2. Drain 16 reads -> data 0x00..0x0F in order, empty=1; extra read -> udf_err=1, ptrs hold.
//  3. Full, assert wr_en+rd_en 20 cycles -> count stays 16, no ovf_err, in-order data across
//     pointer wrap.
//  4. DEPTH=12, 30 write/read interleaved -> ptrs wrap 11->0, order correct, count <= 12.
//  5. Count 7, flush with wr_en+rd_en -> next cycle count 0, empty=1, errors 0, no write.
//  6. RD_REG=1: write 0xA5, 0x3C, pop -> rd_data=0xA5 with rd_valid=1 one cycle after
//     rd_en; mid-stream rst -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/tdec_param_fifo_pkg.sv
// Shared TDEC FIFO constants and helpers.
// Default geometry and thresholds for TDEC wrap buffers.
package tdec_param_fifo_pkg;

    localparam int TDEC_DW    = 8;
    localparam int TDEC_DEPTH = 16;
    localparam int TDEC_AF    = 12;
    localparam int TDEC_AE    = 2;

    function automatic int ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/tdec_fifo_ram.sv
// FIFO storage: DEPTH x DW, one write port, one async read port.
// Contents are deliberately not reset.
module tdec_fifo_ram #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tdec_param_fifo.sv
// Parametrised single-clock FIFO between TDEC wrappers and decoder core.
// Flags are registered from next count; errors are sticky until rst/flush.
module tdec_param_fifo
    import tdec_param_fifo_pkg::*;
#(
    parameter int DW       = TDEC_DW,
    parameter int DEPTH    = TDEC_DEPTH,
    parameter int AW       = ptr_w(DEPTH),
    parameter int AF_THRES = TDEC_AF,
    parameter int AE_THRES = TDEC_AE,
    parameter int RD_REG   = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          fifo_empty,
    output logic          fifo_full,
    output logic          fifo_almost_full,
    output logic          fifo_almost_empty,
    output logic [AW:0]   fifo_count,
    output logic          ovf_err,
    output logic          udf_err
);

    if (DEPTH < 2) begin : g_bad_depth
        $error("tdec_param_fifo: DEPTH must be >= 2");
    end
    if (AW != ptr_w(DEPTH)) begin : g_bad_aw
        $error("tdec_param_fifo: AW is derived from DEPTH");
    end
    if (AF_THRES < 1 || AF_THRES > DEPTH) begin : g_bad_af
        $error("tdec_param_fifo: AF_THRES out of range");
    end
    if (AE_THRES < 0 || AE_THRES > DEPTH - 1) begin : g_bad_ae
        $error("tdec_param_fifo: AE_THRES out of range");
    end

    localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_AF    = (AW+1)'(AF_THRES);
    localparam logic [AW:0]   CNT_AE    = (AW+1)'(AE_THRES);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_nxt;
    logic [DW-1:0] ram_rdata;
    logic          rd_acc;
    logic          wr_acc;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    assign rd_acc = rd_en & ~fifo_empty;
    assign wr_acc = wr_en & (~fifo_full | rd_acc);

    always_comb begin
        count_nxt = fifo_count;
        unique case (1'b1)
            (wr_acc & ~rd_acc): count_nxt = fifo_count + CNT_ONE;
            (rd_acc & ~wr_acc): count_nxt = fifo_count - CNT_ONE;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            fifo_count        <= '0;
            fifo_empty        <= 1'b1;
            fifo_full         <= 1'b0;
            fifo_almost_full  <= 1'b0;
            fifo_almost_empty <= 1'b1;
            ovf_err           <= 1'b0;
            udf_err           <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
            fifo_count        <= count_nxt;
            fifo_empty        <= (count_nxt == '0);
            fifo_full         <= (count_nxt == CNT_DEPTH);
            fifo_almost_full  <= (count_nxt >= CNT_AF);
            fifo_almost_empty <= (count_nxt <= CNT_AE);
            if (wr_en & fifo_full & ~rd_acc) ovf_err <= 1'b1;
            if (rd_en & fifo_empty)          udf_err <= 1'b1;
        end
    end

    tdec_fifo_ram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc & ~rst & ~flush),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    if (RD_REG != 0) begin : g_rd_reg
        logic [DW-1:0] rd_q;
        logic          rd_v;

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_q <= '0;
                rd_v <= 1'b0;
            end else if (flush) begin
                rd_v <= 1'b0;
            end else if (rd_acc) begin
                rd_q <= ram_rdata;
                rd_v <= 1'b1;
            end else begin
                rd_v <= 1'b0;
            end
        end

        assign rd_data  = rd_q;
        assign rd_valid = rd_v;
    end else begin : g_rd_comb
        assign rd_data  = ram_rdata;
        assign rd_valid = ~fifo_empty;
    end

endmodule

// File: tb/tb_tdec_param_fifo.sv
// Bench for tdec_param_fifo: three instances checked against a queue model.
// u0: DEPTH 16 show-ahead, u1: DEPTH 12 show-ahead, u2: DEPTH 16 registered read.
module tb_tdec_param_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_v   [3];
    logic       flush_v [3];
    logic       wr_v    [3];
    logic       rd_v    [3];
    logic [7:0] wd_v    [3];

    logic [7:0] rdd [3];
    logic       rv  [3];
    logic       emp [3];
    logic       ful [3];
    logic       af  [3];
    logic       ae  [3];
    logic [4:0] cnt [3];
    logic       ovf [3];
    logic       udf [3];

    int nchk = 0;
    int nbad = 0;
    bit chk_en = 1'b0;

    tdec_param_fifo #(.DW(8), .DEPTH(16), .AF_THRES(12), .AE_THRES(2), .RD_REG(0)) u0 (
        .clk(clk), .rst(rst_v[0]), .flush(flush_v[0]),
        .wr_en(wr_v[0]), .wr_data(wd_v[0]), .rd_en(rd_v[0]),
        .rd_data(rdd[0]), .rd_valid(rv[0]), .fifo_empty(emp[0]), .fifo_full(ful[0]),
        .fifo_almost_full(af[0]), .fifo_almost_empty(ae[0]), .fifo_count(cnt[0]),
        .ovf_err(ovf[0]), .udf_err(udf[0])
    );

    tdec_param_fifo #(.DW(8), .DEPTH(12), .AF_THRES(9), .AE_THRES(2), .RD_REG(0)) u1 (
        .clk(clk), .rst(rst_v[1]), .flush(flush_v[1]),
        .wr_en(wr_v[1]), .wr_data(wd_v[1]), .rd_en(rd_v[1]),
        .rd_data(rdd[1]), .rd_valid(rv[1]), .fifo_empty(emp[1]), .fifo_full(ful[1]),
        .fifo_almost_full(af[1]), .fifo_almost_empty(ae[1]), .fifo_count(cnt[1]),
        .ovf_err(ovf[1]), .udf_err(udf[1])
    );

    tdec_param_fifo #(.DW(8), .DEPTH(16), .AF_THRES(12), .AE_THRES(2), .RD_REG(1)) u2 (
        .clk(clk), .rst(rst_v[2]), .flush(flush_v[2]),
        .wr_en(wr_v[2]), .wr_data(wd_v[2]), .rd_en(rd_v[2]),
        .rd_data(rdd[2]), .rd_valid(rv[2]), .fifo_empty(emp[2]), .fifo_full(ful[2]),
        .fifo_almost_full(af[2]), .fifo_almost_empty(ae[2]), .fifo_count(cnt[2]),
        .ovf_err(ovf[2]), .udf_err(udf[2])
    );

    // Reference model: a plain queue per instance plus sticky error bits.
    logic [7:0] mq [3][$];
    int         md  [3] = '{16, 12, 16};
    int         maf [3] = '{12, 9, 12};
    int         mae [3] = '{2, 2, 2};
    bit         m_ovf  [3];
    bit         m_udf  [3];
    bit         m_rv   [3];
    logic [7:0] m_rdat [3];

    task automatic check(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_step(input int k);
        int n;
        bit racc;
        bit wacc;
        if (rst_v[k]) begin
            mq[k].delete();
            m_ovf[k]  = 0;
            m_udf[k]  = 0;
            m_rv[k]   = 0;
            m_rdat[k] = 8'h00;
        end else if (flush_v[k]) begin
            mq[k].delete();
            m_ovf[k] = 0;
            m_udf[k] = 0;
            m_rv[k]  = 0;
        end else begin
            n    = mq[k].size();
            racc = rd_v[k] && (n > 0);
            wacc = wr_v[k] && ((n < md[k]) || racc);
            if (wr_v[k] && (n == md[k]) && !racc) m_ovf[k] = 1;
            if (rd_v[k] && (n == 0)) m_udf[k] = 1;
            m_rv[k] = racc;
            if (racc) m_rdat[k] = mq[k].pop_front();
            if (wacc) mq[k].push_back(wd_v[k]);
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) model_step(k);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                int n;
                n = mq[k].size();
                check($sformatf("u%0d count", k), int'(cnt[k]), n);
                check($sformatf("u%0d empty", k), int'(emp[k]), int'(n == 0));
                check($sformatf("u%0d full", k), int'(ful[k]), int'(n == md[k]));
                check($sformatf("u%0d afull", k), int'(af[k]), int'(n >= maf[k]));
                check($sformatf("u%0d aempty", k), int'(ae[k]), int'(n <= mae[k]));
                check($sformatf("u%0d ovf", k), int'(ovf[k]), int'(m_ovf[k]));
                check($sformatf("u%0d udf", k), int'(udf[k]), int'(m_udf[k]));
                if (k == 2) begin
                    check("u2 rd_valid", int'(rv[k]), int'(m_rv[k]));
                    check("u2 rd_data", int'(rdd[k]), int'(m_rdat[k]));
                end else begin
                    check($sformatf("u%0d rd_valid", k), int'(rv[k]), int'(n > 0));
                    if (n > 0)
                        check($sformatf("u%0d rd_data", k), int'(rdd[k]), int'(mq[k][0]));
                end
            end
        end
    end

    task automatic drive(input int k, input bit r, input bit f,
                         input bit w, input logic [7:0] d, input bit rd);
        rst_v[k]   = r;
        flush_v[k] = f;
        wr_v[k]    = w;
        wd_v[k]    = d;
        rd_v[k]    = rd;
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_v[k]   = 1'b0;
        flush_v[k] = 1'b0;
        wr_v[k]    = 1'b0;
        wd_v[k]    = 8'h00;
        rd_v[k]    = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_v[k]   = 1'b1;
            flush_v[k] = 1'b0;
            wr_v[k]    = 1'b0;
            rd_v[k]    = 1'b0;
            wd_v[k]    = 8'h00;
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) rst_v[k] = 1'b0;
        chk_en = 1'b1;

        check("reset count", int'(cnt[0]), 0);
        check("reset empty", int'(emp[0]), 1);
        check("reset aempty", int'(ae[0]), 1);
        check("reset full", int'(ful[0]), 0);
        check("reset u2 rd_valid", int'(rv[2]), 0);
        check("reset u2 rd_data", int'(rdd[2]), 0);

        // Fill to full, then one rejected write.
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 1, 8'(i), 0);
            if (i == 1)  check("fill aempty at 2", int'(ae[0]), 1);
            if (i == 2)  check("fill aempty at 3", int'(ae[0]), 0);
            if (i == 10) check("fill afull at 11", int'(af[0]), 0);
            if (i == 11) check("fill afull at 12", int'(af[0]), 1);
        end
        check("fill count 16", int'(cnt[0]), 16);
        check("fill full", int'(ful[0]), 1);
        check("fill no ovf", int'(ovf[0]), 0);
        drive(0, 0, 0, 1, 8'hEE, 0);
        check("extra write ovf", int'(ovf[0]), 1);
        check("extra write count", int'(cnt[0]), 16);

        // Drain in order, then underflow.
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain data %0d", i), int'(rdd[0]), i);
            drive(0, 0, 0, 0, 8'h00, 1);
        end
        check("drain empty", int'(emp[0]), 1);
        check("drain no udf", int'(udf[0]), 0);
        drive(0, 0, 0, 0, 8'h00, 1);
        check("extra read udf", int'(udf[0]), 1);
        check("extra read count", int'(cnt[0]), 0);
        drive(0, 0, 0, 1, 8'h77, 0);
        check("ptr hold data", int'(rdd[0]), 8'h77);

        drive(0, 0, 1, 0, 8'h00, 0);
        check("flush count", int'(cnt[0]), 0);
        check("flush ovf", int'(ovf[0]), 0);
        check("flush udf", int'(udf[0]), 0);

        // Full with simultaneous push/pop across the wrap.
        for (int i = 0; i < 16; i++) drive(0, 0, 0, 1, 8'(8'h80 + i), 0);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("fullrw data %0d", i), int'(rdd[0]),
                  (i < 16) ? (8'h80 + i) : (8'h40 + i - 16));
            drive(0, 0, 0, 1, 8'(8'h40 + i), 1);
        end
        check("fullrw count", int'(cnt[0]), 16);
        check("fullrw no ovf", int'(ovf[0]), 0);

        // Flush with concurrent write/read at count 7.
        drive(0, 0, 1, 0, 8'h00, 0);
        drive(0, 0, 0, 0, 8'h00, 1);
        check("pre-flush udf", int'(udf[0]), 1);
        for (int i = 0; i < 7; i++) drive(0, 0, 0, 1, 8'(8'h10 + i), 0);
        check("pre-flush count", int'(cnt[0]), 7);
        drive(0, 0, 1, 1, 8'h99, 1);
        check("flush rw count", int'(cnt[0]), 0);
        check("flush rw empty", int'(emp[0]), 1);
        check("flush rw udf", int'(udf[0]), 0);
        check("flush rw ovf", int'(ovf[0]), 0);
        drive(0, 0, 0, 1, 8'h55, 0);
        check("post-flush data", int'(rdd[0]), 8'h55);
        check("post-flush count", int'(cnt[0]), 1);

        // DEPTH 12: interleaved traffic, pointers wrap twice.
        for (int i = 0; i < 30; i++) drive(1, 0, 0, 1, 8'(i + 1), (i % 3) != 0);
        check("d12 count", int'(cnt[1]), 10);
        check("d12 head", int'(rdd[1]), 21);
        check("d12 afull", int'(af[1]), 1);
        check("d12 full", int'(ful[1]), 0);

        // Registered read port.
        drive(2, 0, 0, 1, 8'hA5, 0);
        drive(2, 0, 0, 1, 8'h3C, 0);
        check("rreg pre-pop valid", int'(rv[2]), 0);
        check("rreg count 2", int'(cnt[2]), 2);
        drive(2, 0, 0, 0, 8'h00, 1);
        check("rreg pop1 valid", int'(rv[2]), 1);
        check("rreg pop1 data", int'(rdd[2]), 8'hA5);
        drive(2, 0, 0, 0, 8'h00, 0);
        check("rreg idle valid", int'(rv[2]), 0);
        check("rreg idle hold", int'(rdd[2]), 8'hA5);
        drive(2, 0, 0, 0, 8'h00, 1);
        check("rreg pop2 data", int'(rdd[2]), 8'h3C);
        for (int i = 0; i < 3; i++) drive(2, 0, 0, 1, 8'(i + 1), 0);
        drive(2, 0, 0, 0, 8'h00, 1);
        check("rreg pop3 data", int'(rdd[2]), 1);
        drive(2, 1, 0, 1, 8'hFF, 1);
        check("rreg rst count", int'(cnt[2]), 0);
        check("rreg rst data", int'(rdd[2]), 0);
        check("rreg rst valid", int'(rv[2]), 0);
        check("rreg rst empty", int'(emp[2]), 1);
        check("rreg rst aempty", int'(ae[2]), 1);

        drive(2, 0, 0, 0, 8'h00, 0);
        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end

endmodule
